// File: rtl/sync_fifo_pkg.sv
// Shared types for the synchronous FIFO.
//   fifo_read_mode_e : FWFT (r_data shows the head entry combinationally)
//                      REGISTERED (r_data loaded on each accepted read)
package sync_fifo_pkg;

  typedef enum logic {
    FWFT       = 1'b0,
    REGISTERED = 1'b1
  } fifo_read_mode_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one write port, one asynchronous read port. Not reset.
// Ports:
//   clk    : write clock
//   w_en   : write enable, stores w_data at w_addr on the rising edge
//   w_addr : write address
//   w_data : write data
//   r_addr : read address
//   r_data : mem[r_addr], combinational
module sync_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (w_en) begin
      mem_q[w_addr] <= w_data;
    end
  end

  assign r_data = mem_q[r_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky
// overflow/underflow flags.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   w_inc, w_data         : write request and data; accepted when !w_full
//   w_full, w_almost_full : full flag, count >= AF_LEVEL
//   r_inc, r_data         : read request and data; accepted when !r_empty
//   r_empty, r_almost_empty : empty flag, count <= AE_LEVEL
//   count                 : registered occupancy
//   overflow, underflow   : sticky until reset
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned     DATA_WIDTH = 8,
  parameter int unsigned     ADDR_WIDTH = 4,
  parameter fifo_read_mode_e READ_MODE  = FWFT,
  parameter int unsigned     AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned     AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_inc,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_full,
  output logic                  w_almost_full,
  input  logic                  r_inc,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_empty,
  output logic                  r_almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned PtrW  = ADDR_WIDTH + 1;
  localparam logic [PtrW-1:0] AfLvl = PtrW'(AF_LEVEL);
  localparam logic [PtrW-1:0] AeLvl = PtrW'(AE_LEVEL);

  if (AF_LEVEL > Depth || AE_LEVEL >= Depth || ADDR_WIDTH < 1) begin : g_param_check
    $error("sync_fifo: illegal AF_LEVEL/AE_LEVEL/ADDR_WIDTH");
  end

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PtrW-1:0] w_ptr_q, w_ptr_d;
  logic [PtrW-1:0] r_ptr_q, r_ptr_d;
  logic [PtrW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            full, empty, w_acc, r_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign empty = (w_ptr_q == r_ptr_q);
  assign full  = (w_ptr_q[ADDR_WIDTH-1:0] == r_ptr_q[ADDR_WIDTH-1:0]) &&
                 (w_ptr_q[ADDR_WIDTH] != r_ptr_q[ADDR_WIDTH]);

  always_comb begin
    w_acc   = w_inc && !full;
    r_acc   = r_inc && !empty;
    w_ptr_d = w_ptr_q + PtrW'(w_acc);
    r_ptr_d = r_ptr_q + PtrW'(r_acc);
    // Modulo-2**PtrW difference of the next pointers keeps count aligned with them.
    count_d = w_ptr_d - r_ptr_d;
    ovf_d   = ovf_q | (w_inc & full);
    udf_d   = udf_q | (r_inc & empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .w_en  (w_acc),
    .w_addr(w_ptr_q[ADDR_WIDTH-1:0]),
    .w_data(w_data),
    .r_addr(r_ptr_q[ADDR_WIDTH-1:0]),
    .r_data(mem_rdata)
  );

  if (READ_MODE == REGISTERED) begin : g_reg
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

    always_comb begin
      r_data_d = r_data_q;
      if (r_acc) begin
        r_data_d = mem_rdata;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data_q <= '0;
      end else begin
        r_data_q <= r_data_d;
      end
    end

    assign r_data = r_data_q;
  end else begin : g_fwft
    assign r_data = mem_rdata;
  end

  assign w_full         = full;
  assign r_empty        = empty;
  assign count          = count_q;
  assign w_almost_full  = (count_q >= AfLvl);
  assign r_almost_empty = (count_q <= AeLvl);
  assign overflow       = ovf_q;
  assign underflow      = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised scoreboard bench for sync_fifo: one FWFT and one REGISTERED instance share
// stimulus; a queue model predicts occupancy, flags and read data.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = DEPTH - 2;
  localparam int unsigned AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_inc = 1'b0;
  logic          r_inc = 1'b0;
  logic [DW-1:0] w_data = '0;

  logic          f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
  logic [DW-1:0] f_rdata;
  logic [AW:0]   f_count;
  logic          g_full, g_af, g_empty, g_ae, g_ovf, g_udf;
  logic [DW-1:0] g_rdata;
  logic [AW:0]   g_count;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(FWFT)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .w_inc(w_inc), .w_data(w_data), .w_full(f_full),
    .w_almost_full(f_af), .r_inc(r_inc), .r_data(f_rdata), .r_empty(f_empty),
    .r_almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(REGISTERED)) dut_reg (
    .clk(clk), .rst_n(rst_n), .w_inc(w_inc), .w_data(w_data), .w_full(g_full),
    .w_almost_full(g_af), .r_inc(r_inc), .r_data(g_rdata), .r_empty(g_empty),
    .r_almost_empty(g_ae), .count(g_count), .overflow(g_ovf), .underflow(g_udf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] sb_fwft[$];
  logic [DW-1:0] sb_reg[$];
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  logic [DW-1:0] reg_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read-data monitor: inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("reg_rdata", 32'(g_rdata), 32'(reg_exp));
      if (r_inc && !f_empty) begin
        chk("fwft_sb_has_entry", 32'(sb_fwft.size() != 0), 32'd1);
        if (sb_fwft.size() != 0) chk("fwft_rdata", 32'(f_rdata), 32'(sb_fwft.pop_front()));
      end
      if (r_inc && !g_empty) begin
        chk("reg_sb_has_entry", 32'(sb_reg.size() != 0), 32'd1);
        if (sb_reg.size() != 0) reg_exp = sb_reg.pop_front();
      end
    end
  end

  task automatic check_flags(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ":f_count"}, 32'(f_count), 32'(n));
    chk({tag, ":g_count"}, 32'(g_count), 32'(n));
    chk({tag, ":f_full"},  32'(f_full),  32'(n == DEPTH));
    chk({tag, ":g_full"},  32'(g_full),  32'(n == DEPTH));
    chk({tag, ":f_empty"}, 32'(f_empty), 32'(n == 0));
    chk({tag, ":g_empty"}, 32'(g_empty), 32'(n == 0));
    chk({tag, ":f_af"},    32'(f_af),    32'(n >= AF));
    chk({tag, ":g_af"},    32'(g_af),    32'(n >= AF));
    chk({tag, ":f_ae"},    32'(f_ae),    32'(n <= AE));
    chk({tag, ":g_ae"},    32'(g_ae),    32'(n <= AE));
    chk({tag, ":f_ovf"},   32'(f_ovf),   32'(m_ovf));
    chk({tag, ":g_ovf"},   32'(g_ovf),   32'(m_ovf));
    chk({tag, ":f_udf"},   32'(f_udf),   32'(m_udf));
    chk({tag, ":g_udf"},   32'(g_udf),   32'(m_udf));
  endtask

  // Called at posedge+1; drives one cycle of stimulus and updates the model.
  task automatic step(input string tag, input bit w, input bit r, input logic [DW-1:0] d);
    bit full_m;
    bit empty_m;
    full_m  = (model_q.size() == DEPTH);
    empty_m = (model_q.size() == 0);
    w_inc  = w;
    r_inc  = r;
    w_data = d;
    if (r && !empty_m) begin
      sb_fwft.push_back(model_q[0]);
      sb_reg.push_back(model_q[0]);
      void'(model_q.pop_front());
    end
    if (w && !full_m) model_q.push_back(d);
    if (w && full_m) m_ovf = 1'b1;
    if (r && empty_m) m_udf = 1'b1;
    @(posedge clk);
    #1;
    check_flags(tag);
  endtask

  task automatic clear_model();
    model_q.delete();
    sb_fwft.delete();
    sb_reg.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    reg_exp = '0;
  endtask

  task automatic drain(input string tag);
    while (model_q.size() != 0) step(tag, 1'b0, 1'b1, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_flags("reset");
    chk("reset:g_rdata", 32'(g_rdata), 32'd0);

    // Fill 0x01..0x10, then overflow attempts while full.
    for (int i = 1; i <= 16; i++) step("fill", 1'b1, 1'b0, DW'(i));
    step("ovf_write", 1'b1, 1'b0, 8'hAA);
    step("full_wr_rd", 1'b1, 1'b1, 8'h77);
    drain("drain1");

    // Empty with simultaneous write/read.
    step("empty_wr_rd", 1'b1, 1'b1, 8'h55);
    drain("drain2");

    // Read-mode latency: registered value must hold across idle cycles.
    step("rm_write", 1'b1, 1'b0, 8'h3C);
    step("rm_idle", 1'b0, 1'b0, '0);
    step("rm_read", 1'b0, 1'b1, '0);
    repeat (3) step("rm_hold", 1'b0, 1'b0, '0);

    // Wrap-around with alternating write/read.
    for (int i = 0; i < 40; i++) begin
      step("wrap_w", 1'b1, 1'b0, DW'(8'h80 + i));
      step("wrap_r", 1'b0, 1'b1, '0);
    end

    // Random traffic, write-heavy then read-heavy to visit both boundaries.
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 70 : 30;
      step("rand", $urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
           DW'($urandom));
    end

    // Mid-operation asynchronous reset with 9 entries stored.
    drain("drain3");
    for (int i = 0; i < 9; i++) step("fill9", 1'b1, 1'b0, DW'($urandom));
    w_inc = 1'b0;
    r_inc = 1'b0;
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_flags("async_rst");
    chk("async_rst:g_rdata", 32'(g_rdata), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_flags("post_rst");

    for (int i = 0; i < 100; i++) begin
      step("rand2", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, DW'($urandom));
    end
    drain("drain4");
    step("final_idle", 1'b0, 1'b0, '0);
    chk("sb_fwft_empty", 32'(sb_fwft.size()), 32'd0);
    chk("sb_reg_empty", 32'(sb_reg.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
